seg_display_arbiter: RTL and testbench

- Owns the 4-digit seven-segment display and shares it between two value sources.
- Source A is the default owner (power meter). Source B is the event/score message, which has priority and pre-empts A for a minimum hold time.
- The selected value is converted to BCD sequentially by a shift-add-3 engine, replacing divide/modulo logic, and latched whole.
- The latched BCD is scanned onto AN/digit at a prescaled refresh rate.

---
 rtl/seg_display_arbiter.sv | 251 +++++++++++++++++++++++++
 tb/tb_seg_display_arbiter.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/seg_display_arbiter.sv
// -----------------------------------------------------------------------------
// seg_display_arbiter
//
// Purpose:
//   Shares a 4-digit seven-segment display between two value sources.
//   Source A is the default owner. Source B pre-empts A on request and
//   keeps the display for at least HOLD_CYCLES clocks. The selected value is
//   saturated to 9999 and converted to BCD with a sequential shift-add-3
//   (double dabble) engine. The result is latched whole and then scanned
//   onto the digit enables at a prescaled refresh rate.
//
// Parameters:
//   REFRESH_DIV  clk cycles per digit slot (>= 2)
//   HOLD_CYCLES  minimum clk cycles source B owns the display (>= 1)
//   VAL_W        width of both value inputs (max displayed value 9999)
//
// Ports:
//   clk        in   system clock
//   rst        in   synchronous active-high reset
//   val_a      in   source A value (default owner)
//   req_b      in   source B display request (level)
//   val_b      in   source B value
//   owner_b    out  1 = source B currently owns the display
//   bcd_valid  out  one-cycle pulse when a new BCD result is latched
//   AN         out  active-low digit enables, AN[0] = ones digit
//   digit      out  BCD nibble for the enabled digit
//
// Build option:
//   LZ_BLANK_EN  when defined, leading zeros are blanked (AN slot = 1,
//                digit = 0). The ones digit is never blanked.
// -----------------------------------------------------------------------------
module seg_display_arbiter #(
    parameter int REFRESH_DIV = 2500,
    parameter int HOLD_CYCLES = 100000,
    parameter int VAL_W       = 14
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [VAL_W-1:0] val_a,
    input  logic             req_b,
    input  logic [VAL_W-1:0] val_b,
    output logic             owner_b,
    output logic             bcd_valid,
    output logic [3:0]       AN,
    output logic [3:0]       digit
);

    // -------------------------------------------------------------------------
    // Local constants
    // -------------------------------------------------------------------------
    localparam int HOLD_W  = $clog2(HOLD_CYCLES + 1);
    localparam int PRESC_W = $clog2(REFRESH_DIV);
    localparam int CNT_W   = $clog2(VAL_W + 1);
    localparam int MAX_DISP = 9999;

    localparam logic [HOLD_W-1:0]  HOLD_RELOAD = HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [PRESC_W-1:0] PRESC_LAST  = PRESC_W'(REFRESH_DIV - 1);
    localparam logic [CNT_W-1:0]   SHIFT_LAST  = CNT_W'(VAL_W - 1);
    localparam logic [VAL_W-1:0]   SAT_VALUE   = VAL_W'(MAX_DISP);

    typedef enum logic [1:0] {
        S_LOAD  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } conv_state_t;

    // -------------------------------------------------------------------------
    // Arbitration state
    // -------------------------------------------------------------------------
    logic              r_owner_b;
    logic [HOLD_W-1:0] r_hold_cnt;

    // -------------------------------------------------------------------------
    // Conversion state
    // -------------------------------------------------------------------------
    conv_state_t       r_state;
    logic [VAL_W-1:0]  r_bin;       // sampled binary, MSB consumed first
    logic [15:0]       r_bcd_sr;    // working BCD shift register
    logic [CNT_W-1:0]  r_bit_cnt;   // shift steps taken in this conversion
    logic [15:0]       r_bcd;       // last complete result, shown on display
    logic              r_bcd_valid;

    // -------------------------------------------------------------------------
    // Scan state
    // -------------------------------------------------------------------------
    logic [PRESC_W-1:0] r_presc;
    logic [1:0]         r_scan_idx;
    logic [3:0]         r_an;
    logic [3:0]         r_digit;

    // -------------------------------------------------------------------------
    // Combinational helpers
    // -------------------------------------------------------------------------
    logic [VAL_W-1:0] w_sel;
    logic [VAL_W-1:0] w_sat;
    logic [15:0]      w_bcd_adj;
    logic [3:0]       w_nibble;
    logic [3:0]       w_an_slot;
    logic             w_blank;

    // Source select and clamp to the largest 4-digit value.
    assign w_sel = r_owner_b ? val_b : val_a;
    assign w_sat = (32'(w_sel) > 32'(MAX_DISP)) ? SAT_VALUE : w_sel;

    // Add-3 correction applied to every nibble before each shift, so that a
    // nibble >= 5 carries correctly into the next decade after doubling.
    always_comb begin
        // NOTE: every signal assigned in always_comb gets a default first so
        // no path leaves it unassigned, which would infer a latch.
        w_bcd_adj = r_bcd_sr;
        for (int n = 0; n < 4; n++) begin
            if (r_bcd_sr[4*n +: 4] >= 4'd5) begin
                w_bcd_adj[4*n +: 4] = r_bcd_sr[4*n +: 4] + 4'd3;
            end
        end
    end

    // Nibble and enable pattern for the current scan slot.
    always_comb begin
        w_nibble  = 4'd0;
        w_an_slot = 4'b1111;
        case (r_scan_idx)
            2'd0: begin w_nibble = r_bcd[3:0];   w_an_slot = 4'b1110; end
            2'd1: begin w_nibble = r_bcd[7:4];   w_an_slot = 4'b1101; end
            2'd2: begin w_nibble = r_bcd[11:8];  w_an_slot = 4'b1011; end
            default: begin w_nibble = r_bcd[15:12]; w_an_slot = 4'b0111; end
        endcase
    end

`ifdef LZ_BLANK_EN
    // A slot is a leading zero when it and every more-significant nibble are
    // zero. The ones slot always shows, so a value of 0 reads as "0".
    always_comb begin
        w_blank = 1'b0;
        case (r_scan_idx)
            2'd1:    w_blank = (r_bcd[15:4]  == 12'd0);
            2'd2:    w_blank = (r_bcd[15:8]  == 8'd0);
            2'd3:    w_blank = (r_bcd[15:12] == 4'd0);
            default: w_blank = 1'b0;
        endcase
    end
`else
    assign w_blank = 1'b0;
`endif

    // -------------------------------------------------------------------------
    // Arbitration: B is granted on request and then held for HOLD_CYCLES.
    // The hold only re-arms at expiry, so dropping req_b early never shortens
    // the current hold window.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values of the others.
        if (rst) begin
            r_owner_b  <= 1'b0;
            r_hold_cnt <= '0;
        end else if (!r_owner_b) begin
            if (req_b) begin
                r_owner_b  <= 1'b1;
                r_hold_cnt <= HOLD_RELOAD;
            end
        end else if (r_hold_cnt != '0) begin
            r_hold_cnt <= r_hold_cnt - 1'b1;
        end else if (req_b) begin
            r_hold_cnt <= HOLD_RELOAD;
        end else begin
            r_owner_b <= 1'b0;
        end
    end

    // -------------------------------------------------------------------------
    // Conversion FSM: LOAD (1) -> SHIFT (VAL_W) -> DONE (1), free running.
    // The owner is only consulted in LOAD, so an ownership change never
    // disturbs a conversion in flight, and r_bcd is written only from DONE
    // so it never holds a partial result.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_LOAD;
            r_bin       <= '0;
            r_bcd_sr    <= '0;
            r_bit_cnt   <= '0;
            r_bcd       <= '0;
            r_bcd_valid <= 1'b0;
        end else begin
            r_bcd_valid <= 1'b0;
            case (r_state)
                S_LOAD: begin
                    r_bin     <= w_sat;
                    r_bcd_sr  <= '0;
                    r_bit_cnt <= '0;
                    r_state   <= S_SHIFT;
                end
                S_SHIFT: begin
                    r_bcd_sr <= {w_bcd_adj[14:0], r_bin[VAL_W-1]};
                    r_bin    <= r_bin << 1;
                    if (r_bit_cnt == SHIFT_LAST) begin
                        r_state <= S_DONE;
                    end else begin
                        r_bit_cnt <= r_bit_cnt + 1'b1;
                    end
                end
                S_DONE: begin
                    r_bcd       <= r_bcd_sr;
                    r_bcd_valid <= 1'b1;
                    r_state     <= S_LOAD;
                end
                default: begin
                    r_state <= S_LOAD;
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Display scan. AN/digit are registered from the current slot index, so
    // they trail the index by one clock; a new r_bcd shows on the next clock.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_presc    <= '0;
            r_scan_idx <= 2'd0;
            r_an       <= 4'b1111;
            r_digit    <= 4'd0;
        end else begin
            if (r_presc == PRESC_LAST) begin
                r_presc    <= '0;
                r_scan_idx <= r_scan_idx + 2'd1;   // 3 wraps to 0
            end else begin
                r_presc <= r_presc + 1'b1;
            end

            if (w_blank) begin
                r_an    <= 4'b1111;
                r_digit <= 4'd0;
            end else begin
                r_an    <= w_an_slot;
                r_digit <= w_nibble;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign owner_b   = r_owner_b;
    assign bcd_valid = r_bcd_valid;
    assign AN        = r_an;
    assign digit     = r_digit;

endmodule

// File: tb/tb_seg_display_arbiter.sv
// -----------------------------------------------------------------------------
// tb_seg_display_arbiter
//
// Directed self-checking bench for seg_display_arbiter with
// REFRESH_DIV=4, HOLD_CYCLES=32, VAL_W=14. Outputs are sampled on the falling
// edge; inputs change on the falling edge. Expected display digits come from
// a decimal model of the value the bench applies.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_seg_display_arbiter;

    localparam int REFRESH_DIV = 4;
    localparam int HOLD_CYCLES = 32;
    localparam int VAL_W       = 14;

    logic             clk;
    logic             rst;
    logic [VAL_W-1:0] val_a;
    logic             req_b;
    logic [VAL_W-1:0] val_b;
    logic             owner_b;
    logic             bcd_valid;
    logic [3:0]       AN;
    logic [3:0]       digit;

    int n_checks = 0;
    int n_errors = 0;

    seg_display_arbiter #(
        .REFRESH_DIV (REFRESH_DIV),
        .HOLD_CYCLES (HOLD_CYCLES),
        .VAL_W       (VAL_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .val_a     (val_a),
        .req_b     (req_b),
        .val_b     (val_b),
        .owner_b   (owner_b),
        .bcd_valid (bcd_valid),
        .AN        (AN),
        .digit     (digit)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // -------------------------------------------------------------------------
    // Helpers
    // -------------------------------------------------------------------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int pow10(input int s);
        int p = 1;
        for (int k = 0; k < s; k++) p = p * 10;
        return p;
    endfunction

    function automatic logic [3:0] digit_of(input int v, input int s);
        return 4'((v / pow10(s)) % 10);
    endfunction

    function automatic bit slot_blank(input int v, input int s);
`ifdef LZ_BLANK_EN
        return (s > 0) && (v < pow10(s));
`else
        return 1'b0;
`endif
    endfunction

    // Waits for the next bcd_valid pulse, at most 40 cycles.
    task automatic wait_valid(input string tag);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bcd_valid && n < 40);
        check(tag, bcd_valid, 1'b1);
    endtask

    // Samples 16 cycles (4 slots x REFRESH_DIV) and checks every sample
    // against the decimal digits of v, plus slot coverage and blank count.
    task automatic check_display(input string tag, input int v);
        logic [3:0] seen;
        logic [3:0] exp_seen;
        int         blanks;
        int         exp_blanks;
        bit         matched;
        seen       = 4'b0000;
        exp_seen   = 4'b0000;
        blanks     = 0;
        exp_blanks = 0;
        for (int s = 0; s < 4; s++) begin
            if (slot_blank(v, s)) exp_blanks += 4;
            else                  exp_seen[s] = 1'b1;
        end
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            matched = 1'b0;
            for (int s = 0; s < 4; s++) begin
                if (AN == ~(4'b0001 << s)) begin
                    matched = 1'b1;
                    seen[s] = 1'b1;
                    check($sformatf("%s_digit%0d", tag, s), digit, digit_of(v, s));
                end
            end
            if (AN == 4'b1111) begin
                matched = 1'b1;
                blanks++;
                check($sformatf("%s_blank_digit", tag), digit, 4'd0);
            end
            if (!matched) check($sformatf("%s_an_onehot", tag), AN, 4'b1110);
        end
        check($sformatf("%s_slots", tag), seen, exp_seen);
        check($sformatf("%s_blanks", tag), blanks, exp_blanks);
    endtask

    // Called on the falling edge where rst has just been deasserted: the
    // next 16 cycles scan a zero result, and bcd_valid first rises after the
    // 16th rising edge.
    task automatic check_release(input string tag);
        logic [3:0] exp_an;
        int         slot;
        for (int i = 1; i <= 16; i++) begin
            @(negedge clk);
            slot = (i - 1) / 4;
            exp_an = slot_blank(0, slot) ? 4'b1111 : ~(4'b0001 << slot);
            check($sformatf("%s_an_c%0d", tag, i), AN, exp_an);
            check($sformatf("%s_digit_c%0d", tag, i), digit, 4'd0);
            check($sformatf("%s_valid_c%0d", tag, i), bcd_valid, (i == 16));
            if (i == 1) check($sformatf("%s_owner", tag), owner_b, 1'b0);
        end
    endtask

    // -------------------------------------------------------------------------
    // Directed sequence
    // -------------------------------------------------------------------------
    initial begin
        int cnt;

        rst   = 1'b1;
        val_a = 14'd157;
        req_b = 1'b0;
        val_b = '0;
        repeat (3) @(negedge clk);

        // Reset state
        check("rst_owner", owner_b, 1'b0);
        check("rst_valid", bcd_valid, 1'b0);
        check("rst_an", AN, 4'b1111);
        check("rst_digit", digit, 4'd0);
        rst = 1'b0;

        // First conversion after release and scan order, then 157 on display
        check_release("rel1");
        check_display("disp157", 157);

        // Saturation above 9999
        val_a = 14'd12000;
        wait_valid("sat12000_v1");
        wait_valid("sat12000_v2");
        check_display("sat12000", 9999);

        val_a = 14'd10000;
        wait_valid("sat10000_v1");
        wait_valid("sat10000_v2");
        check_display("sat10000", 9999);

        // One-cycle request from B: exactly HOLD_CYCLES cycles of ownership
        val_a = 14'd42;
        val_b = 14'd3051;
        wait_valid("a42_v1");
        wait_valid("a42_v2");
        check_display("disp42", 42);
        check("pre_pulse_owner", owner_b, 1'b0);
        req_b = 1'b1;
        @(negedge clk);
        req_b = 1'b0;
        cnt = 0;
        while (owner_b && cnt < 100) begin
            cnt++;
            @(negedge clk);
        end
        check("pulse_hold_len", cnt, 32);
        // The last two conversions sampled B, so 3051 stays up for 16 cycles
        check_display("disp3051", 3051);
        wait_valid("back_a_v1");
        wait_valid("back_a_v2");
        check_display("back42", 42);

        // req_b held 100 cycles: reloads at 32, 64, 96 -> drops at 128
        req_b = 1'b1;
        @(negedge clk);
        cnt = 0;
        while (cnt < 300) begin
            if (!owner_b) break;
            cnt++;
            if (cnt == 100) req_b = 1'b0;
            @(negedge clk);
        end
        check("held_hold_len", cnt, 128);
        check("held_owner_after", owner_b, 1'b0);

        // Input change during SHIFT does not corrupt the in-flight result
        val_a = 14'd157;
        wait_valid("mid_v1");
        wait_valid("mid_v2");
        repeat (3) @(negedge clk);
        val_a = 14'd999;
        check_display("mid_still157", 157);
        wait_valid("mid_v3");
        check_display("mid_now999", 999);

        // Reset during a hold and a conversion
        req_b = 1'b1;
        @(negedge clk);
        req_b = 1'b0;
        repeat (5) @(negedge clk);
        check("pre_rst_owner", owner_b, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        check("rst2_owner", owner_b, 1'b0);
        check("rst2_valid", bcd_valid, 1'b0);
        check("rst2_an", AN, 4'b1111);
        check("rst2_digit", digit, 4'd0);
        rst = 1'b0;
        check_release("rel2");
        check_display("after_rst999", 999);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
